// File: rtl/rect_pkg.sv
// Shared constants for the rectangle blit engine: FSM state encoding and default geometry.
package rect_pkg;

  localparam int unsigned XW_DEF         = 8;
  localparam int unsigned YW_DEF         = 7;
  localparam int unsigned DW_DEF         = 5;
  localparam int unsigned CW_DEF         = 3;
  localparam int unsigned XSCREEN_DEF    = 160;
  localparam int unsigned YSCREEN_DEF    = 120;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO (power-of-two depth) holding packed rectangle commands.
module rect_cmd_fifo
  import rect_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_s;
  logic             pop_s;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == {(AW+1){1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_q[rptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= {WIDTH{1'b0}};
      wptr_q <= {AW{1'b0}};
      rptr_q <= {AW{1'b0}};
      cnt_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rect_blit_engine.sv
// Queued rectangle-fill engine: raster-sweeps each queued rectangle onto the VGA adapter port.
// Optional screen clipping is enabled by defining RECT_CLIP_EN.
module rect_blit_engine
  import rect_pkg::*;
#(
  parameter int unsigned XW         = XW_DEF,
  parameter int unsigned YW         = YW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned CW         = CW_DEF,
`ifdef RECT_CLIP_EN
  parameter int unsigned XSCREEN    = XSCREEN_DEF,
  parameter int unsigned YSCREEN    = YSCREEN_DEF,
`endif
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [DW-1:0] cmd_w,
  input  logic [DW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_colour,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam int unsigned FW = XW + YW + 2*DW + CW;

  logic [FW-1:0] fifo_wdata_s, fifo_rdata_s;
  logic          fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
  logic [XW-1:0] head_x_s;
  logic [YW-1:0] head_y_s;
  logic [DW-1:0] head_w_s, head_h_s;
  logic [CW-1:0] head_c_s;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, vga_x_q, vga_x_d;
  logic [YW-1:0] y0_q, y0_d, vga_y_q, vga_y_d;
  logic [DW-1:0] w_q, w_d, h_q, h_d, cx_q, cx_d, cy_q, cy_d;
  logic [CW-1:0] col_q, col_d, vga_c_q, vga_c_d;
  logic          plot_q, plot_d, done_q, done_d;
`ifdef RECT_CLIP_EN
  logic [XW:0]   x_ext_s;
  logic [YW:0]   y_ext_s;
`endif

  assign fifo_wdata_s = {cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour};
  assign fifo_push_s  = cmd_valid && !fifo_full_s;
  assign {head_x_s, head_y_s, head_w_s, head_h_s, head_c_s} = fifo_rdata_s;

  rect_cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (resetn),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sequencer: IDLE -> LOAD (pop + latch) -> DRAW (w*h cycles) -> DONE -> IDLE.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    fifo_pop_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) state_d = S_LOAD;
        else               state_d = S_IDLE;
      end
      S_LOAD: begin
        fifo_pop_s = 1'b1;
        x0_d  = head_x_s;
        y0_d  = head_y_s;
        w_d   = head_w_s;
        h_d   = head_h_s;
        col_d = head_c_s;
        cx_d  = {DW{1'b0}};
        cy_d  = {DW{1'b0}};
        if (head_w_s == {DW{1'b0}} || head_h_s == {DW{1'b0}}) state_d = S_DONE;
        else                                                  state_d = S_DRAW;
      end
      S_DRAW: begin
        if (cx_q == w_q - DW'(1)) begin
          cx_d = {DW{1'b0}};
          if (cy_q == h_q - DW'(1)) state_d = S_DONE;
          else                      cy_d    = cy_q + DW'(1);
        end else begin
          cx_d = cx_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next pixel is derived from next-state counters so the registered strobe lines up with DRAW.
  always_comb begin
    vga_x_d = x0_d + XW'(cx_d);
    vga_y_d = y0_d + YW'(cy_d);
    vga_c_d = col_d;
    done_d  = (state_d == S_DONE);
`ifdef RECT_CLIP_EN
    x_ext_s = {1'b0, x0_d} + (XW+1)'(cx_d);
    y_ext_s = {1'b0, y0_d} + (YW+1)'(cy_d);
    plot_d  = (state_d == S_DRAW) && (x_ext_s < (XW+1)'(XSCREEN)) && (y_ext_s < (YW+1)'(YSCREEN));
`else
    plot_d  = (state_d == S_DRAW);
`endif
  end

  // State, command latches, counters and registered adapter outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x0_q    <= {XW{1'b0}};
      y0_q    <= {YW{1'b0}};
      w_q     <= {DW{1'b0}};
      h_q     <= {DW{1'b0}};
      col_q   <= {CW{1'b0}};
      cx_q    <= {DW{1'b0}};
      cy_q    <= {DW{1'b0}};
      vga_x_q <= {XW{1'b0}};
      vga_y_q <= {YW{1'b0}};
      vga_c_q <= {CW{1'b0}};
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      vga_c_q <= vga_c_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready  = !fifo_full_s;
  assign busy       = (state_q != S_IDLE) || !fifo_empty_s;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_c_q;
  assign plot       = plot_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rect_blit_engine.sv
// Directed testbench for rect_blit_engine; expectations adapt when RECT_CLIP_EN is defined.
module tb_rect_blit_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = 8'd0;
  logic [6:0] cmd_y = 7'd0;
  logic [4:0] cmd_w = 5'd0;
  logic [4:0] cmd_h = 5'd0;
  logic [2:0] cmd_colour = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done;

  rect_blit_engine dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_colour (cmd_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel/done monitor sampled on the falling edge.
  logic [7:0] qx[$];
  logic [6:0] qy[$];
  logic [2:0] qc[$];
  int         qcyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      qx.push_back(vga_x);
      qy.push_back(vga_y);
      qc.push_back(vga_colour);
      qcyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int push_cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    qx.delete(); qy.delete(); qc.delete(); qcyc.delete();
    done_cnt = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic push_cmd(input int x, input int y, input int w, input int h, input int c);
    int g;
    cmd_x = 8'(x); cmd_y = 7'(y); cmd_w = 5'(w); cmd_h = 5'(h); cmd_colour = 3'(c);
    cmd_valid = 1'b1;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check_val("push_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check_val({tag, "_timeout"}, 32'(busy), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic cmp_rect(input int start, input int x0, input int y0, input int w, input int h,
                          input int c, output int bad);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    bad = 0;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        int i;
        i  = start + r * w + k;
        ex = 8'(x0 + k);
        ey = 7'(y0 + r);
        ec = 3'(c);
        if (i >= qx.size()) bad++;
        else if (qx[i] !== ex || qy[i] !== ey || qc[i] !== ec) bad++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n;
    // Reset state
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_plot",  32'(plot), 32'd0);
    check_val("rst_done",  32'(done), 32'd0);
    check_val("rst_busy",  32'(busy), 32'd0);
    check_val("rst_xyc",   32'({vga_x, vga_y, vga_colour}), 32'd0);

    // 1: 10x10 at (80,60), colour 4
    clear_mon();
    push_cmd(80, 60, 10, 10, 4);
    wait_idle("t1");
    check_val("t1_count", 32'(qx.size()), 32'd100);
    if (qx.size() == 100) begin
      check_val("t1_first_cyc", 32'(qcyc[0]), 32'(push_cyc + 2));
      check_val("t1_last_x", 32'(qx[99]), 32'd89);
      check_val("t1_last_y", 32'(qy[99]), 32'd69);
      check_val("t1_nogap", 32'(qcyc[99] - qcyc[0]), 32'd99);
    end
    cmp_rect(0, 80, 60, 10, 10, 4, bad);
    check_val("t1_order", 32'(bad), 32'd0);
    check_val("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("t1_done_cyc", 32'(done_cyc), 32'(push_cyc + 102));

    // 2: five back-to-back 3x2 commands; one pops before the queue fills
    clear_mon();
    for (int k = 0; k < 5; k++) push_cmd(10 + 20 * k, 5 + 10 * k, 3, 2, k + 1);
    check_val("t2_full_ready", 32'(cmd_ready), 32'd0);
    wait_idle("t2");
    check_val("t2_ready_back", 32'(cmd_ready), 32'd1);
    check_val("t2_count", 32'(qx.size()), 32'd30);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cmp_rect(6 * k, 10 + 20 * k, 5 + 10 * k, 3, 2, k + 1, bad);
      n += bad;
    end
    check_val("t2_order", 32'(n), 32'd0);
    check_val("t2_done_cnt", 32'(done_cnt), 32'd5);

    // 3: zero width -> no pixels, done at push+2, busy low one cycle later
    clear_mon();
    push_cmd(5, 5, 0, 3, 1);
    @(negedge clk);
    @(negedge clk);
    check_val("t3_done_cyc", 32'(done), 32'd1);
    @(negedge clk);
    check_val("t3_busy", 32'(busy), 32'd0);
    check_val("t3_done_low", 32'(done), 32'd0);
    #1;
    check_val("t3_count", 32'(qx.size()), 32'd0);

    // 4: rectangle straddling the screen edge
    clear_mon();
    push_cmd(155, 118, 10, 4, 2);
    wait_idle("t4");
    check_val("t4_cycles", 32'(done_cyc - push_cyc), 32'd42);
`ifdef RECT_CLIP_EN
    check_val("t4_count", 32'(qx.size()), 32'd10);
    if (qx.size() == 10) begin
      check_val("t4_last_x", 32'(qx[9]), 32'd159);
      check_val("t4_last_y", 32'(qy[9]), 32'd119);
    end
`else
    check_val("t4_count", 32'(qx.size()), 32'd40);
    cmp_rect(0, 155, 118, 10, 4, 2, bad);
    check_val("t4_order", 32'(bad), 32'd0);
`endif

    // 6: x wrap past 255
    clear_mon();
    push_cmd(250, 20, 10, 1, 7);
    wait_idle("t6");
`ifdef RECT_CLIP_EN
    check_val("t6_count", 32'(qx.size()), 32'd0);
`else
    check_val("t6_count", 32'(qx.size()), 32'd10);
    cmp_rect(0, 250, 20, 10, 1, 7, bad);
    check_val("t6_wrap_seq", 32'(bad), 32'd0);
`endif
    check_val("t6_done_cnt", 32'(done_cnt), 32'd1);

    // 5: reset during the 37th pixel of a 10x10, with a second command queued
    clear_mon();
    push_cmd(80, 60, 10, 10, 3);
    push_cmd(20, 20, 4, 4, 5);
    n = 0;
    while (qx.size() < 37 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("t5_reach37", 32'(qx.size()), 32'd37);
    resetn = 1'b0;
    #1;
    check_val("t5_plot_async", 32'(plot), 32'd0);
    check_val("t5_busy_async", 32'(busy), 32'd0);
    check_val("t5_ready_async", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check_val("t5_no_more_plots", 32'(qx.size()), 32'd37);
    check_val("t5_no_done", 32'(done_cnt), 32'd0);
    check_val("t5_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
